// File: rtl/clock_gate_ctrl.sv
// Clock-enable controller for a downstream clock gate.
// Drops the enable after a programmable run of idle cycles and restores it
// on idle exit or on a wake request, acknowledging requests only once the
// restarted clock has had WAKE_DELAY cycles to settle.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | clock running; counting consecutive idle cycles
//   OFF   | clock gated; waiting for a wake request or idle to drop
//   WAKE  | clock re-enabled; counting settle cycles before RUN
module clock_gate_ctrl #(
  parameter int CNT_WIDTH  = 8,
  parameter int WAKE_DELAY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_en_i,
  input  logic                 idle_i,
  input  logic [CNT_WIDTH-1:0] idle_thresh_i,
  input  logic                 wake_req_i,
  output logic                 wake_ack_o,
  output logic                 clk_en_o,
  output logic                 gated_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_t;

  // Counter arithmetic is done one bit wider so cnt + 1 never wraps and the
  // threshold compare stays monotonic even with a saturated counter.
  localparam logic [CNT_WIDTH:0] ONE_EXT   = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH:0] WAKE_LAST = (CNT_WIDTH+1)'(WAKE_DELAY);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic                 armed_q, armed_d;
  logic                 clk_en_q, clk_en_d;
  logic                 gated_q, gated_d;
  logic [CNT_WIDTH:0]   cnt_inc;
  logic [CNT_WIDTH:0]   thresh_ext;

  assign cnt_inc    = {1'b0, cnt_q} + ONE_EXT;
  assign thresh_ext = {1'b0, idle_thresh_i};

  // Next-state, counter and registered-output logic.
  // armed tracks the handshake edge: it is cleared by an ack and re-set
  // only once wake_req_i has been sampled low, so a held request acks once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    armed_d = armed_q | ~wake_req_i;

    case (state_q)
      ST_RUN: begin
        if (wake_req_i) begin
          cnt_d = '0;
          if (armed_q) begin
            ack_d   = 1'b1;
            armed_d = 1'b0;
          end
        end else if (!idle_i || (idle_thresh_i == '0)) begin
          cnt_d = '0;
        end else if (cnt_inc >= thresh_ext) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (&cnt_q) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_inc[CNT_WIDTH-1:0];
        end
      end

      ST_OFF: begin
        if (wake_req_i || !idle_i) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end

      ST_WAKE: begin
        // idle_i is deliberately ignored here; counting restarts in RUN.
        if (cnt_inc >= WAKE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          if (wake_req_i && armed_q) begin
            ack_d   = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc[CNT_WIDTH-1:0];
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    clk_en_d = (state_d != ST_OFF);
    gated_d  = (state_d == ST_OFF);
  end

  // State and output registers; the clock runs out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      armed_q  <= 1'b1;
      clk_en_q <= 1'b1;
      gated_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      armed_q  <= armed_d;
      clk_en_q <= clk_en_d;
      gated_q  <= gated_d;
    end
  end

  // test_en_i bypasses the register so DFT can force the clock on at once.
  assign clk_en_o   = clk_en_q | test_en_i;
  assign wake_ack_o = ack_q;
  assign gated_o    = gated_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl (CNT_WIDTH = 8, WAKE_DELAY = 2).
module tb_clock_gate_ctrl;

  logic       clk;
  logic       rst_n;
  logic       test_en;
  logic       idle;
  logic [7:0] thresh;
  logic       wake_req;
  logic       wake_ack;
  logic       clk_en;
  logic       gated;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       te;
    logic       idle;
    logic       req;
    logic [7:0] thr;
    logic       en;
    logic       ack;
    logic       gated;
  } vec_t;

  typedef struct {
    logic en;
    logic ack;
    logic gated;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  clock_gate_ctrl #(.CNT_WIDTH(8), .WAKE_DELAY(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .test_en_i    (test_en),
    .idle_i       (idle),
    .idle_thresh_i(thresh),
    .wake_req_i   (wake_req),
    .wake_ack_o   (wake_ack),
    .clk_en_o     (clk_en),
    .gated_o      (gated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic te, input logic id, input logic rq, input logic [7:0] thr,
                     input logic en, input logic ack, input logic g);
    vec_t v;
    v.te = te; v.idle = id; v.req = rq; v.thr = thr;
    v.en = en; v.ack = ack; v.gated = g;
    vecs.push_back(v);
  endtask

  // Drive one vector before an edge, expect its outputs just after that edge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    test_en  = v.te;
    idle     = v.idle;
    wake_req = v.req;
    thresh   = v.thr;
    e.en = v.en; e.ack = v.ack; e.gated = v.gated;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " clk_en"}, clk_en, e.en);
      check({tag, " ack"}, wake_ack, e.ack);
      check({tag, " gated"}, gated, e.gated);
    end
  endtask

  task automatic step_io(input logic te, input logic id, input logic rq, input logic [7:0] thr,
                         input logic en, input logic ack, input logic g, input string tag);
    vec_t v;
    v.te = te; v.idle = id; v.req = rq; v.thr = thr;
    v.en = en; v.ack = ack; v.gated = g;
    step(v, tag);
  endtask

  task automatic async_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    check({tag, " rst clk_en"}, clk_en, 1'b1);
    check({tag, " rst ack"}, wake_ack, 1'b0);
    check({tag, " rst gated"}, gated, 1'b0);
    idle     = 1'b0;
    wake_req = 1'b0;
    test_en  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b1;
    test_en  = 1'b0;
    idle     = 1'b0;
    thresh   = 8'd3;
    wake_req = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset clk_en", clk_en, 1'b1);
    check("reset ack", wake_ack, 1'b0);
    check("reset gated", gated, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //  te id rq thr   en ack g
    // idle threshold 3: gate after the third idle edge
    add(0, 1, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd3, 0, 0, 1);
    add(0, 1, 0, 8'd3, 0, 0, 1);
    // test_en overrides clk_en in OFF without leaving OFF
    add(1, 1, 0, 8'd3, 1, 0, 1);
    add(0, 1, 0, 8'd3, 0, 0, 1);
    // wake request from OFF: enable next edge, ack two edges later, one cycle
    add(0, 1, 1, 8'd3, 1, 0, 0);
    add(0, 1, 1, 8'd3, 1, 0, 0);
    add(0, 1, 1, 8'd3, 1, 1, 0);
    add(0, 1, 1, 8'd3, 1, 0, 0);
    add(0, 1, 1, 8'd3, 1, 0, 0);
    // idle pattern 1,1,0,1,1,1
    add(0, 1, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd3, 1, 0, 0);
    add(0, 0, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd3, 0, 0, 1);
    // idle exit without request: no ack; idle ignored in WAKE, fresh count in RUN
    add(0, 0, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd3, 0, 0, 1);
    // request arriving during WAKE is acked on RUN entry
    add(0, 0, 0, 8'd3, 1, 0, 0);
    add(0, 0, 1, 8'd3, 1, 0, 0);
    add(0, 0, 1, 8'd3, 1, 1, 0);
    add(0, 0, 0, 8'd3, 1, 0, 0);
    // threshold 1, then request dropped early during WAKE
    add(0, 1, 0, 8'd1, 0, 0, 1);
    add(0, 1, 1, 8'd1, 1, 0, 0);
    add(0, 1, 0, 8'd1, 1, 0, 0);
    add(0, 1, 0, 8'd1, 1, 0, 0);
    // request and idle together in RUN: ack, no gating
    add(0, 1, 1, 8'd1, 1, 1, 0);
    add(0, 1, 1, 8'd1, 1, 0, 0);
    add(0, 1, 0, 8'd1, 0, 0, 1);
    // live threshold lowered below cnt mid-count
    add(0, 0, 0, 8'd10, 1, 0, 0);
    add(0, 0, 0, 8'd10, 1, 0, 0);
    add(0, 0, 0, 8'd10, 1, 0, 0);
    add(0, 1, 0, 8'd10, 1, 0, 0);
    add(0, 1, 0, 8'd10, 1, 0, 0);
    add(0, 1, 0, 8'd10, 1, 0, 0);
    add(0, 1, 0, 8'd2, 0, 0, 1);
    add(0, 0, 0, 8'd2, 1, 0, 0);
    add(0, 0, 0, 8'd2, 1, 0, 0);
    add(0, 0, 0, 8'd2, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // threshold 0 disables gating
    for (int i = 0; i < 300; i++)
      step_io(0, 1, 0, 8'd0, 1, 0, 0, $sformatf("thr0_%0d", i));

    // reach OFF, test_en takes effect immediately
    step_io(0, 1, 0, 8'd3, 1, 0, 0, "off_a1");
    step_io(0, 1, 0, 8'd3, 1, 0, 0, "off_a2");
    step_io(0, 1, 0, 8'd3, 0, 0, 1, "off_a3");
    @(negedge clk);
    test_en = 1'b1;
    #1;
    check("te_imm clk_en", clk_en, 1'b1);
    check("te_imm gated", gated, 1'b1);
    test_en = 1'b0;
    #1;
    check("te_off clk_en", clk_en, 1'b0);

    // reset mid-OFF, then a full count is required again
    async_reset("mid_off");
    step_io(0, 1, 0, 8'd3, 1, 0, 0, "post_rst1");
    step_io(0, 1, 0, 8'd3, 1, 0, 0, "post_rst2");
    step_io(0, 1, 0, 8'd3, 0, 0, 1, "post_rst3");

    // reset mid-WAKE with the request still held
    step_io(0, 1, 1, 8'd3, 1, 0, 0, "wake_in");
    async_reset("mid_wake");
    step_io(0, 1, 1, 8'd3, 1, 1, 0, "run_req_ack");
    step_io(0, 1, 1, 8'd3, 1, 0, 0, "run_req_hold");
    async_reset("mid_run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
